// File: rtl/modn_stream_check.sv
// Framed MSB-first stream remainder checker (mod MOD, DW bits per beat).
// Ports: clk, rst_n, in_vld/in_sof/in_eof/din in; rem, flag_y, res_* and err_orphan out.
module modn_stream_check #(
  parameter int MOD = 3,
  parameter int DW  = 1,
  localparam int RW = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic          in_sof,
  input  logic          in_eof,
  input  logic [DW-1:0] din,
  output logic [RW-1:0] rem,
  output logic          flag_y,
  output logic          res_vld,
  output logic [RW-1:0] res_rem,
  output logic          res_div,
  output logic          err_orphan
);

  if (MOD < 2 || MOD > 255) begin : g_bad_mod
    $error("modn_stream_check: MOD out of range 2..255");
  end
  if (DW < 1 || DW > 8) begin : g_bad_dw
    $error("modn_stream_check: DW out of range 1..8");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RW:0] MODV = MOD[RW:0];

  state_t        state_q, state_d;
  logic [RW-1:0] rem_d;
  logic          res_vld_d;
  logic [RW-1:0] res_rem_d;
  logic          res_div_d;
  logic          err_d;
  logic [RW:0]   b;

  // b < MOD <= 2**RW, so the top bit is always clear before each
  // shift and 2*b+1 fits in RW+1 bits.
  always_comb begin
    b = in_sof ? '0 : {1'b0, rem};
    for (int i = DW - 1; i >= 0; i--) begin
      b = {b[RW-1:0], din[i]};
      if (b >= MODV) b = b - MODV;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem;
    res_vld_d = 1'b0;
    res_rem_d = res_rem;
    res_div_d = res_div;
    err_d     = 1'b0;
    if (in_vld) begin
      unique case (state_q)
        IDLE: begin
          if (!in_sof) begin
            err_d = 1'b1;
          end else begin
            rem_d = b[RW-1:0];
            if (in_eof) begin
              res_vld_d = 1'b1;
              res_rem_d = b[RW-1:0];
              res_div_d = (b == '0);
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          rem_d = b[RW-1:0];
          if (in_eof) begin
            state_d   = IDLE;
            res_vld_d = 1'b1;
            res_rem_d = b[RW-1:0];
            res_div_d = (b == '0);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem        <= '0;
      res_vld    <= 1'b0;
      res_rem    <= '0;
      res_div    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem        <= rem_d;
      res_vld    <= res_vld_d;
      res_rem    <= res_rem_d;
      res_div    <= res_div_d;
      err_orphan <= err_d;
    end
  end

  assign flag_y = (state_q == RUN) && (rem == '0);

endmodule
